// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Digit widths, accumulator sizing and the converter state encoding.
package bcd2bin_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int NUM_DIGITS  = 3;
  localparam int MAX_DIGIT   = 9;
  localparam int ACC_W       = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FINISH = 2'd2
  } state_t;

  function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_DIGIT_W'(MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd2bin_t_mac10.sv
// Combinational multiply-by-ten-and-add step: o_acc = i_acc*10 + i_digit.
// Shift-and-add form keeps it a pair of adders with no multiplier.
module bcd_mac10
  import bcd2bin_pkg::*;
(
  input  logic [ACC_W-1:0]       i_acc,
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [ACC_W-1:0]       o_acc
);

  assign o_acc = (i_acc << 3) + (i_acc << 1) + ACC_W'(i_digit);

endmodule

// File: rtl/bcd2bin_t.sv
// Sequential three-digit signed BCD to two's-complement converter.
// One digit per enabled clock (H, T, U), then a range-checked result with a done pulse.
module bcd2bin_t
  import bcd2bin_pkg::*;
#(
  parameter int WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   start,
  input  logic [3:0]             H,
  input  logic [3:0]             T,
  input  logic [3:0]             U,
  input  logic                   sign,
  output logic [WORD_LENGTH-1:0] bin,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             dbg_state
);

  localparam int unsigned MAX_POS = (32'd1 << (WORD_LENGTH - 1)) - 32'd1;
  localparam int unsigned MAX_NEG = MAX_POS + 32'd1;

  state_t                 r_state, w_state_nxt;
  logic [BCD_DIGIT_W-1:0] r_h, r_t, r_u, w_h_nxt, w_t_nxt, w_u_nxt;
  logic                   r_sign, w_sign_nxt;
  logic [ACC_W-1:0]       r_acc, w_acc_nxt;
  logic [1:0]             r_idx, w_idx_nxt;
  logic                   r_invalid, w_invalid_nxt;
  logic [WORD_LENGTH-1:0] r_bin, w_bin_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_error, w_error_nxt;

  logic [BCD_DIGIT_W-1:0] w_digit;
  logic [ACC_W-1:0]       w_mac;
  logic [WORD_LENGTH-1:0] w_mag;
  logic [31:0]            w_acc32;
  logic                   w_over;

  // Digit index counts down 2,1,0 so hundreds enter the accumulator first.
  always_comb begin
    case (r_idx)
      2'd2:    w_digit = r_h;
      2'd1:    w_digit = r_t;
      default: w_digit = r_u;
    endcase
  end

  bcd_mac10 u_mac (
    .i_acc   (r_acc),
    .i_digit (w_digit),
    .o_acc   (w_mac)
  );

  assign w_mag   = WORD_LENGTH'(r_acc);
  assign w_acc32 = 32'(r_acc);
  // A negative result may reach one further than a positive one.
  assign w_over  = r_sign ? (w_acc32 > MAX_NEG) : (w_acc32 > MAX_POS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_h       <= '0;
      r_t       <= '0;
      r_u       <= '0;
      r_sign    <= 1'b0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_invalid <= 1'b0;
      r_bin     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else if (enable) begin
      r_state   <= w_state_nxt;
      r_h       <= w_h_nxt;
      r_t       <= w_t_nxt;
      r_u       <= w_u_nxt;
      r_sign    <= w_sign_nxt;
      r_acc     <= w_acc_nxt;
      r_idx     <= w_idx_nxt;
      r_invalid <= w_invalid_nxt;
      r_bin     <= w_bin_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_h_nxt       = r_h;
    w_t_nxt       = r_t;
    w_u_nxt       = r_u;
    w_sign_nxt    = r_sign;
    w_acc_nxt     = r_acc;
    w_idx_nxt     = r_idx;
    w_invalid_nxt = r_invalid;
    w_bin_nxt     = r_bin;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_error_nxt   = r_error;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_h_nxt       = H;
          w_t_nxt       = T;
          w_u_nxt       = U;
          w_sign_nxt    = sign;
          w_acc_nxt     = '0;
          w_idx_nxt     = 2'd2;
          w_invalid_nxt = 1'b0;
          w_error_nxt   = 1'b0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = CONV;
        end
      end
      CONV: begin
        w_acc_nxt = w_mac;
        if (digit_invalid(w_digit)) w_invalid_nxt = 1'b1;
        if (r_idx == 2'd0) w_state_nxt = FINISH;
        else               w_idx_nxt   = r_idx - 2'd1;
      end
      FINISH: begin
        if (r_invalid || w_over) begin
          w_bin_nxt   = '0;
          w_error_nxt = 1'b1;
        end else begin
          w_bin_nxt   = r_sign ? (-w_mag) : w_mag;
          w_error_nxt = 1'b0;
        end
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bin       = r_bin;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign dbg_state = r_state;

endmodule
